// File: rtl/anim_frame_sequencer_if.sv
// Bundles the go/frame_done inputs and the animation selection outputs
// exchanged between the frame-source control and the LCD frame path.
interface anim_frame_sequencer_if #(
   parameter int FRAME_W = 4
);
   logic               go;
   logic               frame_done;
   logic               anim_sel;
   logic [FRAME_W-1:0] frame_idx;
   logic               frame_adv;
   logic               anim_done;
   logic               req_pending;

   // master drives requests and frame boundaries; slave is the sequencer
   modport master (
      output go, frame_done,
      input  anim_sel, frame_idx, frame_adv, anim_done, req_pending
   );

   modport slave (
      input  go, frame_done,
      output anim_sel, frame_idx, frame_adv, anim_done, req_pending
   );
endinterface

// File: rtl/anim_frame_sequencer.sv
// Chooses IDLE (looping) or SMILE (one-shot) animation and the frame within it,
// changing selection only at LCD frame boundaries so a refresh is never torn.
module anim_frame_sequencer #(
   parameter int IDLE_FRAMES  = 4,
   parameter int SMILE_FRAMES = 6,
   parameter int HOLD_REFRESH = 3,
   parameter int FRAME_W      = 4,
   parameter int HOLD_W       = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   anim_frame_sequencer_if.slave bus
);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_SMILE = 1'b1
   } state_e;

   localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_REFRESH - 1);
   localparam logic [FRAME_W-1:0] IDLE_LAST  = FRAME_W'(IDLE_FRAMES - 1);
   localparam logic [FRAME_W-1:0] SMILE_LAST = FRAME_W'(SMILE_FRAMES - 1);

   state_e             state_q, state_d;
   logic [FRAME_W-1:0] frame_idx_q, frame_idx_d;
   logic [HOLD_W-1:0]  hold_q, hold_d;
   logic               frame_adv_q, frame_adv_d;
   logic               anim_done_q, anim_done_d;
   logic               pend_q, pend_d;
   logic               go_q;

   logic go_rise, req, hold_exp;

   // A request arriving on the boundary cycle itself is applied immediately.
   assign go_rise  = bus.go & ~go_q;
   assign req      = pend_q | go_rise;
   assign hold_exp = (hold_q == HOLD_LAST);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         frame_idx_q <= '0;
         hold_q      <= '0;
         frame_adv_q <= 1'b0;
         anim_done_q <= 1'b0;
         pend_q      <= 1'b0;
         go_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         frame_idx_q <= frame_idx_d;
         hold_q      <= hold_d;
         frame_adv_q <= frame_adv_d;
         anim_done_q <= anim_done_d;
         pend_q      <= pend_d;
         go_q        <= bus.go;
      end
   end

   // NOTE: every combinational output gets a default first so no path
   // leaves it unassigned and infers a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (bus.frame_done && req) state_d = S_SMILE;
         end
         S_SMILE: begin
            if (bus.frame_done && (req || (hold_exp && frame_idx_q == SMILE_LAST)))
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      frame_idx_d = frame_idx_q;
      hold_d      = hold_q;
      frame_adv_d = 1'b0;
      anim_done_d = 1'b0;
      pend_d      = bus.frame_done ? 1'b0 : req;
      case (state_q)
         S_IDLE: begin
            if (bus.frame_done) begin
               if (req || hold_exp) begin
                  hold_d      = '0;
                  frame_adv_d = 1'b1;
                  frame_idx_d = (req || frame_idx_q == IDLE_LAST) ? '0 : frame_idx_q + 1'b1;
               end else begin
                  hold_d = hold_q + 1'b1;
               end
            end
         end
         S_SMILE: begin
            if (bus.frame_done) begin
               if (req) begin
                  hold_d      = '0;
                  frame_idx_d = '0;
                  frame_adv_d = 1'b1;
               end else if (hold_exp) begin
                  hold_d      = '0;
                  frame_adv_d = 1'b1;
                  if (frame_idx_q == SMILE_LAST) begin
                     frame_idx_d = '0;
                     anim_done_d = 1'b1;
                  end else begin
                     frame_idx_d = frame_idx_q + 1'b1;
                  end
               end else begin
                  hold_d = hold_q + 1'b1;
               end
            end
         end
         default: begin
            frame_idx_d = '0;
            hold_d      = '0;
         end
      endcase
   end

   assign bus.anim_sel    = state_q;
   assign bus.frame_idx   = frame_idx_q;
   assign bus.frame_adv   = frame_adv_q;
   assign bus.anim_done   = anim_done_q;
   assign bus.req_pending = pend_q;

endmodule

// File: tb/tb_anim_frame_sequencer.sv
// Directed bench for anim_frame_sequencer: IDLE loop, SMILE one-shot,
// request/boundary priority, go-edge filtering and mid-animation reset.
module tb_anim_frame_sequencer;

   localparam int FRAME_W = 4;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   int   toggles;
   logic prev_sel;

   always #5 clk = ~clk;

   anim_frame_sequencer_if #(.FRAME_W(FRAME_W)) bus ();

   anim_frame_sequencer #(
      .IDLE_FRAMES (4),
      .SMILE_FRAMES(6),
      .HOLD_REFRESH(3),
      .FRAME_W     (FRAME_W),
      .HOLD_W      (4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Outputs are sampled on the falling edge, so after this task returns the
   // results registered on the frame_done edge are visible.
   task automatic pulse_fd();
      @(negedge clk) bus.frame_done = 1'b1;
      @(negedge clk) bus.frame_done = 1'b0;
   endtask

   task automatic pulse_go();
      @(negedge clk) bus.go = 1'b1;
      @(negedge clk) bus.go = 1'b0;
   endtask

   task automatic check_outs(input string tag, input logic sel, input logic [31:0] idx,
                             input logic adv, input logic done, input logic pend);
      check({tag, ".anim_sel"},    32'(bus.anim_sel),    32'(sel));
      check({tag, ".frame_idx"},   32'(bus.frame_idx),   idx);
      check({tag, ".frame_adv"},   32'(bus.frame_adv),   32'(adv));
      check({tag, ".anim_done"},   32'(bus.anim_done),   32'(done));
      check({tag, ".req_pending"}, 32'(bus.req_pending), 32'(pend));
   endtask

   initial begin
      rst            = 1'b1;
      bus.go         = 1'b0;
      bus.frame_done = 1'b0;
      repeat (3) @(negedge clk);
      check_outs("reset", 1'b0, 0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      @(negedge clk);

      // IDLE loop: frame advances every third refresh, wraps after frame 3
      for (int k = 1; k <= 12; k++) begin
         pulse_fd();
         check_outs($sformatf("idle_loop%0d", k), 1'b0, (k / 3) % 4, (k % 3) == 0, 1'b0, 1'b0);
      end

      // Reach IDLE frame 2, then request mid-frame
      repeat (6) pulse_fd();
      check("idle_at2.frame_idx", 32'(bus.frame_idx), 2);
      pulse_go();
      repeat (2) @(negedge clk);
      check_outs("pending", 1'b0, 2, 1'b0, 1'b0, 1'b1);
      pulse_fd();
      check_outs("to_smile", 1'b1, 0, 1'b1, 1'b0, 1'b0);

      // SMILE plays once: frames 0..5 held 3 refreshes each, then done
      for (int k = 1; k <= 17; k++) begin
         pulse_fd();
         check_outs($sformatf("smile%0d", k), 1'b1, k / 3, (k % 3) == 0, 1'b0, 1'b0);
      end
      pulse_fd();
      check_outs("smile_end", 1'b0, 0, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      check("smile_end_next.anim_done", 32'(bus.anim_done), 0);
      check("smile_end_next.frame_adv", 32'(bus.frame_adv), 0);

      // Request coincident with the final SMILE boundary wins over completion
      pulse_go();
      pulse_fd();
      check("reenter.anim_sel", 32'(bus.anim_sel), 1);
      repeat (17) pulse_fd();
      check("smile_last_hold.frame_idx", 32'(bus.frame_idx), 5);
      @(negedge clk);
      bus.go         = 1'b1;
      bus.frame_done = 1'b1;
      @(negedge clk);
      bus.frame_done = 1'b0;
      check_outs("abort", 1'b0, 0, 1'b1, 1'b0, 1'b0);
      bus.go = 1'b0;
      repeat (2) @(negedge clk);

      // go held high across three boundaries toggles exactly once
      toggles  = 0;
      prev_sel = bus.anim_sel;
      bus.go   = 1'b1;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         bus.frame_done = (c == 50 || c == 100 || c == 150);
         if (bus.anim_sel !== prev_sel) toggles++;
         prev_sel = bus.anim_sel;
      end
      bus.go         = 1'b0;
      bus.frame_done = 1'b0;
      check("go_held.toggles", 32'(toggles), 1);
      check_outs("go_held", 1'b1, 0, 1'b0, 1'b0, 1'b0);

      // Two go pulses before one boundary give a single toggle, nothing queued
      pulse_go();
      @(negedge clk);
      pulse_go();
      @(negedge clk);
      check("two_go.req_pending", 32'(bus.req_pending), 1);
      pulse_fd();
      check_outs("two_go", 1'b0, 0, 1'b1, 1'b0, 1'b0);
      pulse_fd();
      check_outs("two_go_after", 1'b0, 0, 1'b0, 1'b0, 1'b0);

      // Reset during SMILE frame 3 with a captured request discards everything
      pulse_go();
      pulse_fd();
      check("pre_rst.anim_sel", 32'(bus.anim_sel), 1);
      repeat (9) pulse_fd();
      check("pre_rst.frame_idx", 32'(bus.frame_idx), 3);
      pulse_go();
      @(negedge clk);
      check("pre_rst.req_pending", 32'(bus.req_pending), 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_outs("mid_rst", 1'b0, 0, 1'b0, 1'b0, 1'b0);
      pulse_fd();
      check_outs("post_rst", 1'b0, 0, 1'b0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
